xpb_reduce_seq: RTL and testbench

- Sequential reduction stage placed directly upstream of the 5-bit XPB lookup tables in the modular-squaring datapath.
- Accepts one operand: a lower 1024-bit part plus NUM_DIG 5-bit overflow digits.
- Walks the digits one per cycle. For each digit it drives the digit and a table-position index to the XPB table bank, then registers the returned 1024-bit value.
- Accumulates all returned values onto the lower part and presents a single carry-propagated sum with a valid/ready handshake.

---
 rtl/xpb_reduce_seq_pkg.sv | 12 +
 rtl/xpb_reduce_seq_acc_adder.sv | 28 ++
 rtl/xpb_reduce_seq.sv | 113 +++++++++++
 tb/tb_xpb_reduce_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_reduce_seq_pkg.sv
// Shared definitions for the XPB reduction stage: default datapath widths and FSM states.
package xpb_reduce_seq_pkg;
  localparam int XPB_DATA_W = 1024;
  localparam int XPB_DIG_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/xpb_reduce_seq_acc_adder.sv
// Registered wide accumulator: load replaces the sum with a zero-extended value,
// add_en adds a zero-extended word. Load wins when both are asserted.
module xpb_acc_adder
  import xpb_reduce_seq_pkg::*;
#(
  parameter int DATA_W = XPB_DATA_W,
  parameter int GUARD  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       load_val,
  input  logic                    add_en,
  input  logic [DATA_W-1:0]       add_val,
  output logic [DATA_W+GUARD-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {{GUARD{1'b0}}, load_val};
    end else if (add_en) begin
      acc <= acc + {{GUARD{1'b0}}, add_val};
    end
  end

endmodule

// File: rtl/xpb_reduce_seq.sv
// Walks NUM_DIG overflow digits through the XPB table bank one per cycle and sums the
// returned words onto the lower part; fixed latency of NUM_DIG+2 cycles from accept to out_valid.
module xpb_reduce_seq
  import xpb_reduce_seq_pkg::*;
#(
  parameter int DATA_W  = XPB_DATA_W,
  parameter int DIG_W   = XPB_DIG_W,
  parameter int NUM_DIG = 8,
  parameter int IDX_W   = $clog2(NUM_DIG),
  parameter int GUARD   = $clog2(NUM_DIG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_low,
  input  logic [NUM_DIG*DIG_W-1:0] in_hi,
  output logic                     lut_req,
  output logic [IDX_W-1:0]         lut_idx,
  output logic [DIG_W-1:0]         lut_digit,
  input  logic [DATA_W-1:0]        lut_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+GUARD-1:0]  out_sum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q;
  logic [NUM_DIG*DIG_W-1:0]   hi_q;
  logic [DATA_W-1:0]          p_q;
  logic                       pv_q;
  logic                       accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    lut_req   = 1'b0;
    lut_idx   = '0;
    lut_digit = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        lut_req   = 1'b1;
        lut_idx   = cnt_q;
        lut_digit = hi_q[cnt_q*DIG_W +: DIG_W];
        if (cnt_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The table output is registered in p so the wide add sits behind a flop, not the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      p_q   <= '0;
      pv_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hi_q  <= in_hi;
            cnt_q <= '0;
            pv_q  <= 1'b0;
          end
        end
        ISSUE: begin
          p_q   <= lut_data;
          pv_q  <= 1'b1;
          cnt_q <= cnt_q + IDX_W'(1);
        end
        DRAIN: pv_q <= 1'b0;
        default: ;
      endcase
    end
  end

  xpb_acc_adder #(
    .DATA_W (DATA_W),
    .GUARD  (GUARD)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (in_low),
    .add_en   (pv_q),
    .add_val  (p_q),
    .acc      (out_sum)
  );

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Directed bench for xpb_reduce_seq with NUM_DIG=4 and a behavioural XPB table model.
module tb_xpb_reduce_seq;

  localparam int DW = 1024;
  localparam int DG = 5;
  localparam int ND = 4;
  localparam int IW = 2;
  localparam int OW = DW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_low;
  logic [ND*DG-1:0] in_hi;
  logic          lut_req;
  logic [IW-1:0] lut_idx;
  logic [DG-1:0] lut_digit;
  logic [DW-1:0] lut_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;

  logic          lut_all_ones = 1'b0;
  int            vec = 0;
  int            miss = 0;

  always #5 clk = ~clk;

  // Table model: word = (idx+1)*digit, or all ones for the overflow scenario.
  always_comb begin
    lut_data = '0;
    if (lut_all_ones) lut_data = '1;
    else lut_data[15:0] = (16'(lut_idx) + 16'd1) * 16'(lut_digit);
  end

  xpb_reduce_seq #(
    .DATA_W  (DW),
    .DIG_W   (DG),
    .NUM_DIG (ND)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_low    (in_low),
    .in_hi     (in_hi),
    .lut_req   (lut_req),
    .lut_idx   (lut_idx),
    .lut_digit (lut_digit),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // Presents one operand for a single edge; returns at the negedge of the first issue cycle.
  task automatic start_op(input logic [DW-1:0] low, input logic [ND*DG-1:0] hi);
    in_low   = low;
    in_hi    = hi;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges since accept until out_valid, bounded so a dead DUT cannot hang the run.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_low = '0; in_hi = '0; out_ready = 1'b0;
    #12;
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vec++; if (lut_req !== 1'b0) begin miss++; $display("FAIL reset_lut_req: got %b expected 0", lut_req); end
    vec++; if (lut_idx !== 2'd0 || lut_digit !== 5'd0) begin miss++; $display("FAIL reset_lut_addr: got idx %0d digit %0d expected 0 0", lut_idx, lut_digit); end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vec++; if (out_sum !== OW'(0)) begin miss++; $display("FAIL reset_out_sum: got %0h expected 0", out_sum[63:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [ND*DG-1:0] hi;
    hi = {5'd4, 5'd3, 5'd2, 5'd1};
    start_op(DW'(100), hi);
    for (int i = 0; i < ND; i++) begin
      vec++;
      if (lut_req !== 1'b1 || lut_idx !== IW'(i) || lut_digit !== hi[i*DG +: DG]) begin
        miss++;
        $display("FAIL basic_issue%0d: got req %b idx %0d digit %0d expected 1 %0d %0d",
                 i, lut_req, lut_idx, lut_digit, i, hi[i*DG +: DG]);
      end
      vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL basic_in_ready_busy%0d: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    vec++; if (lut_req !== 1'b0 || out_valid !== 1'b0 || lut_idx !== 2'd0) begin miss++; $display("FAIL basic_drain: got req %b valid %b idx %0d expected 0 0 0", lut_req, out_valid, lut_idx); end
    @(negedge clk);
    vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL basic_latency: got out_valid %b at accept+6 expected 1", out_valid); end
    vec++; if (out_sum !== OW'(130)) begin miss++; $display("FAIL basic_sum: got %0d expected 130", out_sum[63:0]); end
    handshake();
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL basic_return_idle: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_zero();
    int n;
    n = 0;
    start_op('0, '0);
    for (int c = 1; c <= 5; c++) begin
      if (lut_req) n++;
      @(negedge clk);
    end
    vec++; if (n !== 4) begin miss++; $display("FAIL zero_req_cycles: got %0d expected 4", n); end
    vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL zero_latency: got out_valid %b expected 1", out_valid); end
    vec++; if (out_sum !== OW'(0)) begin miss++; $display("FAIL zero_sum: got %0h expected 0", out_sum[63:0]); end
    handshake();
  endtask

  task automatic test_max();
    int cyc;
    logic [OW-1:0] exp_sum;
    exp_sum = {3'b000, {DW{1'b1}}};
    exp_sum = (exp_sum << 2) + exp_sum;
    lut_all_ones = 1'b1;
    start_op('1, 20'h5a5a5);
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL max_latency: got %0d cycles expected 6", cyc); end
    vec++;
    if (out_sum !== exp_sum) begin
      miss++;
      $display("FAIL max_sum: got top %h low %h expected top %h low %h",
               out_sum[OW-1:OW-32], out_sum[31:0], exp_sum[OW-1:OW-32], exp_sum[31:0]);
    end
    handshake();
    lut_all_ones = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    start_op(DW'(5), {5'd1, 5'd1, 5'd1, 5'd1});
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL stall_latency: got %0d cycles expected 6", cyc); end
    in_low = DW'(50); in_hi = {5'd0, 5'd0, 5'd0, 5'd2}; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_sum !== OW'(15) || in_ready !== 1'b0) begin
        miss++;
        $display("FAIL stall_hold%0d: got valid %b sum %0d in_ready %b expected 1 15 0",
                 i, out_valid, out_sum[63:0], in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL stall_release: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    vec++; if (lut_req !== 1'b1 || in_ready !== 1'b0) begin miss++; $display("FAIL stall_next_accept: got lut_req %b in_ready %b expected 1 0", lut_req, in_ready); end
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL stall_next_latency: got %0d cycles expected 6", cyc); end
    vec++; if (out_sum !== OW'(52)) begin miss++; $display("FAIL stall_next_sum: got %0d expected 52", out_sum[63:0]); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_op(DW'(1000), {5'd5, 5'd5, 5'd5, 5'd5});
    @(posedge clk);
    #2;
    vec++; if (lut_req !== 1'b1 || lut_idx !== 2'd1) begin miss++; $display("FAIL rmid_pre: got req %b idx %0d expected 1 1", lut_req, lut_idx); end
    rst_n = 1'b0;
    #1;
    vec++; if (lut_req !== 1'b0) begin miss++; $display("FAIL rmid_lut_req: got %b expected 0", lut_req); end
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL rmid_handshake: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    vec++; if (lut_idx !== 2'd0 || lut_digit !== 5'd0) begin miss++; $display("FAIL rmid_lut_addr: got idx %0d digit %0d expected 0 0", lut_idx, lut_digit); end
    vec++; if (out_sum !== OW'(0)) begin miss++; $display("FAIL rmid_sum: got %0h expected 0", out_sum[63:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rmid_no_partial%0d: got out_valid %b expected 0", i, out_valid); end
    end
    start_op(DW'(7), {5'd1, 5'd0, 5'd0, 5'd0});
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL rmid_fresh_latency: got %0d cycles expected 6", cyc); end
    vec++; if (out_sum !== OW'(11)) begin miss++; $display("FAIL rmid_fresh_sum: got %0d expected 11", out_sum[63:0]); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    start_op(DW'(1000), {5'd31, 5'd31, 5'd31, 5'd31});
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL b2b_a_latency: got %0d cycles expected 6", cyc); end
    vec++; if (out_sum !== OW'(1310)) begin miss++; $display("FAIL b2b_a_sum: got %0d expected 1310", out_sum[63:0]); end
    in_low = DW'(3); in_hi = {5'd0, 5'd0, 5'd1, 5'd0}; in_valid = 1'b1;
    @(negedge clk);
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL b2b_gap: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    vec++; if (lut_req !== 1'b1 || lut_digit !== 5'd0) begin miss++; $display("FAIL b2b_b_issue: got req %b digit %0d expected 1 0", lut_req, lut_digit); end
    wait_valid(cyc);
    vec++; if (cyc !== 6) begin miss++; $display("FAIL b2b_b_latency: got %0d cycles expected 6", cyc); end
    vec++; if (out_sum !== OW'(5)) begin miss++; $display("FAIL b2b_b_sum: got %0d expected 5", out_sum[63:0]); end
    @(negedge clk);
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miss++; $display("FAIL b2b_idle: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
